mem_loader: RTL and testbench

Hardware program/data loader for the `monocicle` core. It takes a byte stream over a valid/ready handshake, decodes framed load commands, and writes 32-bit words into instruction memory and bytes into data memory. It holds the core in reset until a GO command arrives. It is the write-side counterpart of the bench's `$readmem`/dump path and replaces backdoor initialisation in synthesised builds.

---
 rtl/mem_loader_pkg.sv | 18 +
 rtl/mem_loader_if.sv | 11 +
 rtl/mem_loader.sv | 165 ++++++++++++++++
 tb/tb_mem_loader.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared constants and FSM state encoding for the byte-stream memory loader.
package loader_pkg;

  localparam logic [7:0] CMD_INST = 8'h49;
  localparam logic [7:0] CMD_DATA = 8'h44;
  localparam logic [7:0] CMD_GO   = 8'h47;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_L  = 3'd1,
    ST_ADDR_H  = 3'd2,
    ST_LEN_L   = 3'd3,
    ST_LEN_H   = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_CHK     = 3'd6
  } state_e;

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface mem_loader_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/mem_loader.sv
// Framed program/data loader: decodes I/D/G commands from a byte stream,
// writes instruction words and data bytes, and holds the core in reset until GO.
module mem_loader
  import loader_pkg::*;
#(
  parameter int IADDR_W = 6,
  parameter int DADDR_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  mem_loader_if.slave        s_if,
  output logic               inst_we,
  output logic [IADDR_W-1:0] inst_addr,
  output logic [31:0]        inst_wdata,
  output logic               data_we,
  output logic [DADDR_W-1:0] data_addr,
  output logic [7:0]         data_wdata,
  output logic               core_rst,
  output logic               done,
  output logic               err
);

  state_e             state_q;
  logic [15:0]        addr_q;
  logic [15:0]        len_q;
  logic [1:0]         lane_q;
  logic [23:0]        word_q;
  logic [7:0]         chk_q;
  logic               rej_q;
  logic               is_inst_q;
  logic               inst_we_q;
  logic [IADDR_W-1:0] inst_addr_q;
  logic [31:0]        inst_wdata_q;
  logic               data_we_q;
  logic [DADDR_W-1:0] data_addr_q;
  logic [7:0]         data_wdata_q;
  logic               core_rst_q;
  logic               done_q;
  logic               err_q;

  logic [15:0]        len_d;
  logic [7:0]         chk_d;

  assign len_d = {s_if.s_data, len_q[7:0]};
  assign chk_d = chk_q ^ s_if.s_data;

  // The loader never back-pressures; only reset withholds ready.
  assign s_if.s_ready = ~RST;

  // Frame decoder, datapath and registered write strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      addr_q       <= 16'd0;
      len_q        <= 16'd0;
      lane_q       <= 2'd0;
      word_q       <= 24'd0;
      chk_q        <= 8'd0;
      rej_q        <= 1'b0;
      is_inst_q    <= 1'b0;
      inst_we_q    <= 1'b0;
      inst_addr_q  <= '0;
      inst_wdata_q <= 32'd0;
      data_we_q    <= 1'b0;
      data_addr_q  <= '0;
      data_wdata_q <= 8'd0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      inst_we_q <= 1'b0;
      data_we_q <= 1'b0;
      if (s_if.s_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (s_if.s_data == CMD_GO) begin
              core_rst_q <= 1'b0;
              done_q     <= 1'b1;
            end else if ((s_if.s_data == CMD_INST) || (s_if.s_data == CMD_DATA)) begin
              // A load command always (re)asserts core reset, covering reload after GO.
              is_inst_q  <= (s_if.s_data == CMD_INST);
              chk_q      <= s_if.s_data;
              rej_q      <= 1'b0;
              core_rst_q <= 1'b1;
              done_q     <= 1'b0;
              state_q    <= ST_ADDR_L;
            end else begin
              err_q <= 1'b1;
            end
          end
          ST_ADDR_L: begin
            addr_q[7:0] <= s_if.s_data;
            chk_q       <= chk_d;
            state_q     <= ST_ADDR_H;
          end
          ST_ADDR_H: begin
            addr_q[15:8] <= s_if.s_data;
            chk_q        <= chk_d;
            state_q      <= ST_LEN_L;
          end
          ST_LEN_L: begin
            len_q[7:0] <= s_if.s_data;
            chk_q      <= chk_d;
            state_q    <= ST_LEN_H;
          end
          ST_LEN_H: begin
            len_q  <= len_d;
            chk_q  <= chk_d;
            lane_q <= 2'd0;
            if (is_inst_q && (len_d[1:0] != 2'd0)) begin
              err_q <= 1'b1;
              rej_q <= 1'b1;
            end
            state_q <= (len_d == 16'd0) ? ST_CHK : ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            chk_q <= chk_d;
            len_q <= len_q - 16'd1;
            if (len_q == 16'd1) begin
              state_q <= ST_CHK;
            end
            if (is_inst_q) begin
              lane_q <= lane_q + 2'd1;
              if (lane_q == 2'd3) begin
                if (!rej_q) begin
                  inst_we_q    <= 1'b1;
                  inst_addr_q  <= addr_q[IADDR_W-1:0];
                  inst_wdata_q <= {s_if.s_data, word_q};
                end
                addr_q <= addr_q + 16'd1;
              end else begin
                // Little-endian packing: earlier bytes shift down toward [7:0].
                word_q <= {s_if.s_data, word_q[23:8]};
              end
            end else begin
              data_we_q    <= 1'b1;
              data_addr_q  <= addr_q[DADDR_W-1:0];
              data_wdata_q <= s_if.s_data;
              addr_q       <= addr_q + 16'd1;
            end
          end
          ST_CHK: begin
            if (s_if.s_data != chk_q) begin
              err_q <= 1'b1;
            end
            rej_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign inst_we    = inst_we_q;
  assign inst_addr  = inst_addr_q;
  assign inst_wdata = inst_wdata_q;
  assign data_we    = data_we_q;
  assign data_addr  = data_addr_q;
  assign data_wdata = data_wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader.
module tb_mem_loader;

  logic        CLK;
  logic        RST;
  logic        inst_we;
  logic [5:0]  inst_addr;
  logic [31:0] inst_wdata;
  logic        data_we;
  logic [7:0]  data_addr;
  logic [7:0]  data_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  mem_loader_if u_if ();

  mem_loader #(.IADDR_W(6), .DADDR_W(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .s_if       (u_if.slave),
    .inst_we    (inst_we),
    .inst_addr  (inst_addr),
    .inst_wdata (inst_wdata),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err)
  );

  int passed = 0;
  int total  = 0;
  int inst_pulses = 0;
  int data_pulses = 0;
  int snap;
  logic [7:0] tb_chk;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (inst_we === 1'b1) inst_pulses = inst_pulses + 1;
    if (data_we === 1'b1) data_pulses = data_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    u_if.s_data  = b;
    u_if.s_valid = 1'b1;
    tb_chk = tb_chk ^ b;
    @(posedge CLK);
    #1;
    u_if.s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    u_if.s_valid = 1'b0;
    u_if.s_data  = 8'h00;
    tb_chk = 8'h00;
    idle(2);
    check("rst_core_rst", {31'd0, core_rst}, 32'd1);
    check("rst_ready_low", {31'd0, u_if.s_ready}, 32'd0);
    check("rst_inst_addr", {26'd0, inst_addr}, 32'd0);
    RST = 1'b0;
    idle(1);
    check("idle_ready", {31'd0, u_if.s_ready}, 32'd1);
    check("idle_strobes", {30'd0, inst_we, data_we}, 32'd0);
    check("idle_err_done", {30'd0, err, done}, 32'd0);

    // 'I' frame, addr 2, len 8: two words
    tb_chk = 8'h00;
    send(8'h49); send(8'h02); send(8'h00); send(8'h08); send(8'h00);
    send(8'h13); send(8'h05); send(8'h A0);
    check("i_no_early_we", {31'd0, inst_we}, 32'd0);
    send(8'h00);
    check("i_w0_we", {31'd0, inst_we}, 32'd1);
    check("i_w0_addr", {26'd0, inst_addr}, 32'd2);
    check("i_w0_data", inst_wdata, 32'h00A00513);
    send(8'h93); send(8'h85); send(8'h15); send(8'h00);
    check("i_w1_addr", {26'd0, inst_addr}, 32'd3);
    check("i_w1_data", inst_wdata, 32'h00158593);
    send(tb_chk);
    check("i_pulses", inst_pulses, 32'd2);
    check("i_err", {31'd0, err}, 32'd0);

    // 'D' frame wrapping at 0xFF with s_valid toggling
    snap = data_pulses;
    tb_chk = 8'h00;
    send(8'h44); idle(1); send(8'hFE); idle(1); send(8'h00); idle(1);
    send(8'h03); idle(1); send(8'h00); idle(1);
    send(8'h11);
    check("d0_we", {31'd0, data_we}, 32'd1);
    check("d0_addr_data", {16'd0, data_addr, data_wdata}, 32'h0000FE11);
    idle(1);
    check("d0_we_one_cycle", {31'd0, data_we}, 32'd0);
    send(8'h22);
    check("d1_addr_data", {16'd0, data_addr, data_wdata}, 32'h0000FF22);
    idle(1);
    send(8'h33);
    check("d2_wrap", {15'd0, data_we, data_addr, data_wdata}, 32'h00010033);
    idle(1);
    send(tb_chk);
    check("d_pulses", data_pulses - snap, 32'd3);
    check("d_err", {31'd0, err}, 32'd0);

    // 'I' frame with len 5 is rejected
    snap = inst_pulses;
    tb_chk = 8'h00;
    send(8'h49); send(8'h00); send(8'h00); send(8'h05);
    check("rej_err_before_lenh", {31'd0, err}, 32'd0);
    send(8'h00);
    check("rej_err_at_lenh", {31'd0, err}, 32'd1);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    send(tb_chk);
    check("rej_no_writes", inst_pulses - snap, 32'd0);
    send(8'h47);
    check("rej_then_go_done", {30'd0, done, core_rst}, 32'd2);

    // Bad checksum on 'D' frame: write stays, err set
    do_reset();
    check("reset_clears", {29'd0, err, done, core_rst}, 32'd1);
    tb_chk = 8'h00;
    send(8'h44); send(8'h10); send(8'h00); send(8'h01); send(8'h00);
    send(8'hAA);
    check("badchk_write", {15'd0, data_we, data_addr, data_wdata}, 32'h000110AA);
    send(tb_chk ^ 8'hFF);
    check("badchk_err", {31'd0, err}, 32'd1);

    // Stray byte in IDLE
    do_reset();
    send(8'h55);
    check("stray_err", {31'd0, err}, 32'd1);

    // GO, reload, then reset mid payload
    do_reset();
    tb_chk = 8'h00;
    send(8'h47);
    check("go", {29'd0, err, done, core_rst}, 32'd2);
    send(8'h44);
    check("reload", {30'd0, done, core_rst}, 32'd1);
    send(8'h00); send(8'h00); send(8'h04); send(8'h00);
    send(8'h01); send(8'h02);
    RST = 1'b1;
    u_if.s_data  = 8'h03;
    u_if.s_valid = 1'b1;
    @(posedge CLK);
    #1;
    u_if.s_valid = 1'b0;
    RST = 1'b0;
    check("midrst_override", {30'd0, data_we, core_rst}, 32'd1);
    tb_chk = 8'h00;
    send(8'h44); send(8'h20); send(8'h00); send(8'h01); send(8'h00);
    send(8'h5A);
    check("fresh_write", {15'd0, data_we, data_addr, data_wdata}, 32'h0001205A);
    send(tb_chk);
    check("fresh_state", {29'd0, err, done, core_rst}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
